// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding memory read, a small FIFO toward decode, HALT detection and redirect.
// Define FETCH_PREFETCH_EN for a 2-entry prefetch buffer; otherwise the buffer holds a single entry.
module fetch_unit (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_data,
  input  logic        mem_done,
  input  logic        mem_stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] inst,
  output logic [15:0] inst_pc2,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        halted
);

`ifdef FETCH_PREFETCH_EN
  localparam logic [1:0] DEPTH = 2'd2;
`else
  localparam logic [1:0] DEPTH = 2'd1;
`endif

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic [15:0] pc_r, pc_s;
  logic [15:0] pc_plus2_s;
  logic [1:0]  count_r;
  logic [15:0] head_data_r, head_pc2_r;
  logic        push_s, pop_s, free_s, halt_word_s;

  assign pc_plus2_s  = pc_r + 16'd2;
  assign pop_s       = inst_valid & inst_ready;
  // A slot popped this cycle is free by the time the response can land.
  assign free_s      = (count_r < DEPTH) | pop_s;
  assign halt_word_s = (mem_data[15:11] == 5'b00000);

  assign mem_addr   = pc_r;
  assign inst       = head_data_r;
  assign inst_pc2   = head_pc2_r;
  assign inst_valid = (count_r != 2'd0);
  assign halted     = (state_r == HALT);

  // Next-state, request and buffer-push decode.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    push_s  = 1'b0;
    mem_rd  = 1'b0;
    case (state_r)
      FETCH: begin
        if (!rst && !redirect && !mem_stall && free_s) begin
          mem_rd  = 1'b1;
          state_s = WAIT;
        end else begin
          state_s = FETCH;
        end
      end
      WAIT: begin
        if (mem_done && redirect) begin
          state_s = FETCH;
        end else if (mem_done) begin
          push_s  = 1'b1;
          pc_s    = pc_plus2_s;
          state_s = halt_word_s ? HALT : FETCH;
        end else if (redirect) begin
          state_s = DRAIN;
        end else begin
          state_s = WAIT;
        end
      end
      // An outstanding response must still be swallowed, even across a redirect.
      DRAIN:   state_s = mem_done ? FETCH : DRAIN;
      HALT:    state_s = redirect ? FETCH : HALT;
      default: state_s = FETCH;
    endcase
    pc_s = redirect ? redirect_pc : pc_s;
  end

  // State and program counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= FETCH;
      pc_r    <= 16'h0000;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
    end
  end

  // Buffer occupancy; a redirect flushes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= 2'd0;
    end else if (redirect) begin
      count_r <= 2'd0;
    end else begin
      count_r <= count_r + {1'b0, push_s} - {1'b0, pop_s};
    end
  end

`ifdef FETCH_PREFETCH_EN
  logic [15:0] tail_data_r, tail_pc2_r;

  // Two-entry shifting FIFO: pop moves tail to head, push lands in the first free slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_data_r <= 16'h0000;
      head_pc2_r  <= 16'h0000;
      tail_data_r <= 16'h0000;
      tail_pc2_r  <= 16'h0000;
    end else begin
      if (pop_s) begin
        head_data_r <= tail_data_r;
        head_pc2_r  <= tail_pc2_r;
      end
      if (push_s) begin
        if (count_r == {1'b0, pop_s}) begin
          head_data_r <= mem_data;
          head_pc2_r  <= pc_plus2_s;
        end else begin
          tail_data_r <= mem_data;
          tail_pc2_r  <= pc_plus2_s;
        end
      end
    end
  end
`else
  // Single-entry buffer: a push always targets the head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_data_r <= 16'h0000;
      head_pc2_r  <= 16'h0000;
    end else if (push_s) begin
      head_data_r <= mem_data;
      head_pc2_r  <= pc_plus2_s;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; expectations are hand-computed per cycle.
// Works for both buffer depths (FETCH_PREFETCH_EN defined or not).
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_done;
  logic        mem_stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] inst;
  logic [15:0] inst_pc2;
  logic        inst_valid;
  logic        inst_ready;
  logic        halted;

  int errors = 0;
  int checks = 0;

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_done(mem_done), .mem_stall(mem_stall),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst(inst), .inst_pc2(inst_pc2), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    logic exp_rd;
    rst = 1'b1; mem_data = 16'h0000; mem_done = 1'b0; mem_stall = 1'b0;
    redirect = 1'b0; redirect_pc = 16'h0000; inst_ready = 1'b0;
    tick(); tick(); #1;
    chk1("rst_valid", inst_valid, 1'b0);
    chk1("rst_mem_rd", mem_rd, 1'b0);
    chk1("rst_halted", halted, 1'b0);
    chk16("rst_inst", inst, 16'h0000);
    chk16("rst_pc2", inst_pc2, 16'h0000);

    // First request right after reset release, then two sequential fetches.
    tick(); rst = 1'b0; inst_ready = 1'b1; #1;
    chk1("first_rd", mem_rd, 1'b1);
    chk16("first_addr", mem_addr, 16'h0000);
    tick(); mem_done = 1'b1; mem_data = 16'h4000; #1;
    chk1("wait_no_rd", mem_rd, 1'b0);
    tick(); mem_done = 1'b0; #1;
    chk1("i0_valid", inst_valid, 1'b1);
    chk16("i0_inst", inst, 16'h4000);
    chk16("i0_pc2", inst_pc2, 16'h0002);
    chk1("rd2", mem_rd, 1'b1);
    chk16("addr2", mem_addr, 16'h0002);
    tick(); mem_done = 1'b1; mem_data = 16'h4800; #1;
    chk1("gap_valid", inst_valid, 1'b0);

    // Decode stalls for six cycles: head held, prefetch only fills free slots.
    for (int i = 0; i < 6; i++) begin
      tick(); inst_ready = 1'b0;
`ifdef FETCH_PREFETCH_EN
      exp_rd = (i == 0); mem_done = (i == 1); mem_data = 16'h5000;
`else
      exp_rd = 1'b0; mem_done = 1'b0;
`endif
      #1;
      chk1("stall_valid", inst_valid, 1'b1);
      chk16("stall_inst", inst, 16'h4800);
      chk16("stall_pc2", inst_pc2, 16'h0004);
      chk1("stall_rd", mem_rd, exp_rd);
    end
    tick(); mem_done = 1'b0; inst_ready = 1'b1; #1;
    chk16("resume_inst", inst, 16'h4800);
    chk1("resume_rd", mem_rd, 1'b1);
`ifdef FETCH_PREFETCH_EN
    chk16("resume_addr", mem_addr, 16'h0006);
`else
    chk16("resume_addr", mem_addr, 16'h0004);
`endif

    // Redirect while waiting; the late 0xFFFF response must be dropped.
    tick(); redirect = 1'b1; redirect_pc = 16'h0100; #1;
`ifdef FETCH_PREFETCH_EN
    chk1("second_valid", inst_valid, 1'b1);
    chk16("second_inst", inst, 16'h5000);
    chk16("second_pc2", inst_pc2, 16'h0006);
`else
    chk1("second_valid", inst_valid, 1'b0);
`endif
    chk1("redir_wait_rd", mem_rd, 1'b0);
    tick(); redirect = 1'b0; #1;
    chk1("flush_valid", inst_valid, 1'b0);
    chk1("drain_rd", mem_rd, 1'b0);
    tick(); mem_done = 1'b1; mem_data = 16'hFFFF; #1;
    chk1("drain_rd2", mem_rd, 1'b0);
    tick(); mem_done = 1'b0; #1;
    chk1("drop_valid", inst_valid, 1'b0);
    chk1("redir_rd", mem_rd, 1'b1);
    chk16("redir_addr", mem_addr, 16'h0100);
    tick(); mem_done = 1'b1; mem_data = 16'h0800; #1;
    chk1("drop_valid2", inst_valid, 1'b0);

    // Redirect from FETCH suppresses the request; then fetch a HALT word at 0x0010.
    tick(); mem_done = 1'b0; redirect = 1'b1; redirect_pc = 16'h0010; #1;
    chk16("r_inst", inst, 16'h0800);
    chk16("r_pc2", inst_pc2, 16'h0102);
    chk1("redir_fetch_rd", mem_rd, 1'b0);
    tick(); redirect = 1'b0; #1;
    chk1("flush2_valid", inst_valid, 1'b0);
    chk1("halt_req_rd", mem_rd, 1'b1);
    chk16("halt_req_addr", mem_addr, 16'h0010);
    tick(); mem_done = 1'b1; mem_data = 16'h0000; #1;
    chk1("pre_halted", halted, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick(); mem_done = 1'b0; inst_ready = (i >= 5); #1;
      if (i == 0) begin
        chk1("halt_valid", inst_valid, 1'b1);
        chk16("halt_inst", inst, 16'h0000);
        chk16("halt_pc2", inst_pc2, 16'h0012);
      end
      chk1("halted", halted, 1'b1);
      chk1("halt_rd", mem_rd, 1'b0);
    end

    // Redirect out of HALT.
    tick(); redirect = 1'b1; redirect_pc = 16'h0020; #1;
    chk1("halt_drained", inst_valid, 1'b0);
    chk1("halted_before", halted, 1'b1);
    tick(); redirect = 1'b0; #1;
    chk1("unhalted", halted, 1'b0);
    chk1("unhalt_rd", mem_rd, 1'b1);
    chk16("unhalt_addr", mem_addr, 16'h0020);
    tick(); mem_done = 1'b1; mem_data = 16'h1234; #1;

    // Wrap from 0xFFFE to 0x0000, plus a 3-cycle memory stall.
    tick(); mem_done = 1'b0; redirect = 1'b1; redirect_pc = 16'hFFFE; #1;
    chk16("u_inst", inst, 16'h1234);
    chk16("u_pc2", inst_pc2, 16'h0022);
    chk1("u_rd", mem_rd, 1'b0);
    tick(); redirect = 1'b0; #1;
    chk1("wrap_rd", mem_rd, 1'b1);
    chk16("wrap_addr", mem_addr, 16'hFFFE);
    tick(); mem_done = 1'b1; mem_data = 16'h2222; #1;
    tick(); mem_done = 1'b0; mem_stall = 1'b1; #1;
    chk16("wrap_inst", inst, 16'h2222);
    chk16("wrap_pc2", inst_pc2, 16'h0000);
    chk1("wrap_valid", inst_valid, 1'b1);
    chk1("stall_rd0", mem_rd, 1'b0);
    tick(); #1;
    chk1("stall_rd1", mem_rd, 1'b0);
    tick(); #1;
    chk1("stall_rd2", mem_rd, 1'b0);
    tick(); mem_stall = 1'b0; #1;
    chk1("unstall_rd", mem_rd, 1'b1);
    chk16("unstall_addr", mem_addr, 16'h0000);
    tick(); mem_done = 1'b1; mem_data = 16'h3333; #1;
    tick(); mem_done = 1'b0; #1;
    chk16("w0_inst", inst, 16'h3333);
    chk16("w0_pc2", inst_pc2, 16'h0002);
    chk1("w0_rd", mem_rd, 1'b1);
    chk16("w0_addr", mem_addr, 16'h0002);

    // Reset while a request is outstanding; its response must be ignored.
    tick(); rst = 1'b1; #1;
    chk1("rst2_valid", inst_valid, 1'b0);
    chk1("rst2_rd", mem_rd, 1'b0);
    chk16("rst2_inst", inst, 16'h0000);
    chk16("rst2_pc2", inst_pc2, 16'h0000);
    tick(); rst = 1'b0; mem_stall = 1'b1; mem_done = 1'b1; mem_data = 16'h4444; #1;
    chk1("stale_rd", mem_rd, 1'b0);
    tick(); mem_done = 1'b0; mem_stall = 1'b0; #1;
    chk1("stale_valid", inst_valid, 1'b0);
    chk1("post_rst_rd", mem_rd, 1'b1);
    chk16("post_rst_addr", mem_addr, 16'h0000);
    tick(); mem_done = 1'b1; mem_data = 16'h4800; #1;
    tick(); mem_done = 1'b0; #1;
    chk1("post_rst_valid", inst_valid, 1'b1);
    chk16("post_rst_inst", inst, 16'h4800);
    chk16("post_rst_pc2", inst_pc2, 16'h0002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
